// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, sync polarity constants,
// colour bus width macro and a constant-width helper.
`ifndef VGA_PKG_SV
`define VGA_PKG_SV

`define VGA_RGB_W(cw) (3*(cw))

package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int COLOR_W_DEF  = 4;

  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`endif

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_clr_n;
    assign o_q = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing: pixel-tick divider, H/V counters, syncs and blanking
// delayed to line up with the pixel generator's pipeline latency.
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int PIPE_LAT = 1,
  localparam int XW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [`VGA_RGB_W(COLOR_W)-1:0] rgb_in,
  output logic [XW-1:0]                  pixel_x,
  output logic [YW-1:0]                  pixel_y,
  output logic                           video_on,
  output logic                           pixel_tick,
  output logic                           line_start,
  output logic                           frame_start,
  output logic                           h_scan,
  output logic                           v_scan,
  output logic [`VGA_RGB_W(COLOR_W)-1:0] rgb
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   DW       = clog2(CLK_DIV);
  localparam int   RGB_W    = `VGA_RGB_W(COLOR_W);
  localparam logic L_ASSERT = (SYNC_POL == SYNC_ACTIVE_HIGH);

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      COLOR_W < 1 || PIPE_LAT < 0 || PIPE_LAT > 8) begin : g_param_check
    $fatal(1, "vga_timing_engine: illegal timing parameters");
  end

  logic [DW-1:0]    r_div_cnt;
  logic [XW-1:0]    r_pixel_x_p0;
  logic [YW-1:0]    r_pixel_y_p0;
  logic             r_video_on_p0;
  logic             r_hsync_act_p0;
  logic             r_vsync_act_p0;
  logic             r_line_start_p0;
  logic             r_frame_start_p0;
  logic             r_h_scan;
  logic             r_v_scan;
  logic [RGB_W-1:0] r_rgb;

  logic             w_div_last;
  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [XW-1:0]    w_h_next;
  logic [YW-1:0]    w_v_next;
  logic [2:0]       w_dly_in;
  logic [2:0]       w_dly_out;

  assign w_div_last = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_tick     = reset && enable && w_div_last;
  assign w_h_wrap   = (r_pixel_x_p0 == XW'(H_TOTAL - 1));
  assign w_v_wrap   = (r_pixel_y_p0 == YW'(V_TOTAL - 1));

  always_comb begin
    w_h_next = r_pixel_x_p0;
    w_v_next = r_pixel_y_p0;
    if (w_tick) begin
      w_h_next = w_h_wrap ? '0 : r_pixel_x_p0 + 1'b1;
      if (w_h_wrap) w_v_next = w_v_wrap ? '0 : r_pixel_y_p0 + 1'b1;
    end
  end

  // Stage p0: counters and every per-position flag load from the next-state
  // count, so coordinates, video_on and raw syncs all move on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt        <= '0;
      r_pixel_x_p0     <= '0;
      r_pixel_y_p0     <= '0;
      r_video_on_p0    <= 1'b0;
      r_hsync_act_p0   <= 1'b0;
      r_vsync_act_p0   <= 1'b0;
      r_line_start_p0  <= 1'b0;
      r_frame_start_p0 <= 1'b0;
    end else begin
      if (enable) r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      r_pixel_x_p0     <= w_h_next;
      r_pixel_y_p0     <= w_v_next;
      r_video_on_p0    <= (w_h_next < XW'(H_ACTIVE)) && (w_v_next < YW'(V_ACTIVE));
      r_hsync_act_p0   <= (w_h_next >= XW'(H_ACTIVE + H_FP)) &&
                          (w_h_next <  XW'(H_ACTIVE + H_FP + H_SYNC));
      r_vsync_act_p0   <= (w_v_next >= YW'(V_ACTIVE + V_FP)) &&
                          (w_v_next <  YW'(V_ACTIVE + V_FP + V_SYNC));
      r_line_start_p0  <= w_tick && w_h_wrap;
      r_frame_start_p0 <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  // Frozen timing feeds blank into the delay line so rgb drains to black.
  assign w_dly_in = {r_hsync_act_p0, r_vsync_act_p0, r_video_on_p0 & enable};

  vga_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT)
  ) u_sync_dly (
    .i_clk  (clk),
    .i_clr_n(reset),
    .i_d    (w_dly_in),
    .o_q    (w_dly_out)
  );

  // Output stage: polarity applied here; syncs hold their level while frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h_scan <= ~L_ASSERT;
      r_v_scan <= ~L_ASSERT;
      r_rgb    <= '0;
    end else begin
      if (enable) begin
        r_h_scan <= w_dly_out[2] ? L_ASSERT : ~L_ASSERT;
        r_v_scan <= w_dly_out[1] ? L_ASSERT : ~L_ASSERT;
      end
      r_rgb <= w_dly_out[0] ? rgb_in : '0;
    end
  end

  assign pixel_x     = r_pixel_x_p0;
  assign pixel_y     = r_pixel_y_p0;
  assign video_on    = r_video_on_p0;
  assign pixel_tick  = w_tick;
  assign line_start  = r_line_start_p0 & enable;
  assign frame_start = r_frame_start_p0 & enable;
  assign h_scan      = r_h_scan;
  assign v_scan      = r_v_scan;
  assign rgb         = r_rgb;

endmodule
